// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end to one shared 8-bit ALU.
// Provides lockable ownership with idle timeout and registered, back-pressurable responses.
`default_nettype none

module alu_arbiter #(
    parameter int LOCK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_req_valid_i,
    output logic       a_req_ready_o,
    input  logic [3:0] a_req_op_i,
    input  logic [7:0] a_req_x_i,
    input  logic [7:0] a_req_y_i,
    input  logic       a_req_lock_i,
    output logic       a_rsp_valid_o,
    input  logic       a_rsp_ready_i,
    output logic [7:0] a_rsp_data_o,
    output logic       a_rsp_carry_o,
    input  logic       b_req_valid_i,
    output logic       b_req_ready_o,
    input  logic [3:0] b_req_op_i,
    input  logic [7:0] b_req_x_i,
    input  logic [7:0] b_req_y_i,
    input  logic       b_req_lock_i,
    output logic       b_rsp_valid_o,
    input  logic       b_rsp_ready_i,
    output logic [7:0] b_rsp_data_o,
    output logic       b_rsp_carry_o
);

    localparam int CW = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(LOCK_TIMEOUT);

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } lock_t;

    lock_t         lock_q;
    logic [CW-1:0] cnt_q;
    logic          rr_q;          // 1: B was granted most recently
    logic          a_vld_q, b_vld_q;
    logic [8:0]    a_res_q, b_res_q;
    logic          a_vld_d, b_vld_d;
    logic [8:0]    a_res_d, b_res_d;

    logic       free_a, free_b, elig_a, elig_b, grant_a, grant_b;
    logic       own_valid, own_grant, own_lock, timeout_hit;
    logic [3:0] alu_op;
    logic [7:0] alu_x, alu_y;
    logic [8:0] alu_res;

    function automatic logic [8:0] alu_eval(input logic [3:0] op, input logic [7:0] x,
                                            input logic [7:0] y);
        logic [8:0] r;
        r = 9'd0;
        case (op)
            4'h0: r = {1'b0, y};
            4'h1: r = {1'b0, x | y};
            4'h2: r = {1'b0, x & y};
            4'h3: r = {1'b0, x ^ y};
            4'h4: r = {1'b0, x} + {1'b0, y};
            4'h5: r = {(x >= y), 8'(x - y)};
            4'h6: r = {x[0], 1'b0, x[7:1]};
            4'h7: r = {(y >= x), 8'(y - x)};
            4'hF: r = {x[7], x[6:0], 1'b0};
            default: r = 9'd0;
        endcase
        return r;
    endfunction

    assign free_a  = !a_vld_q || a_rsp_ready_i;
    assign free_b  = !b_vld_q || b_rsp_ready_i;
    assign elig_a  = a_req_valid_i && free_a && (lock_q == FREE || lock_q == OWN_A);
    assign elig_b  = b_req_valid_i && free_b && (lock_q == FREE || lock_q == OWN_B);
    // Ready is forced low while reset is asserted so nothing is accepted during it.
    assign grant_a = rst_n && elig_a && (!elig_b || rr_q);
    assign grant_b = rst_n && elig_b && (!elig_a || !rr_q);

    assign a_req_ready_o = grant_a;
    assign b_req_ready_o = grant_b;

    assign alu_op  = grant_a ? a_req_op_i : b_req_op_i;
    assign alu_x   = grant_a ? a_req_x_i  : b_req_x_i;
    assign alu_y   = grant_a ? a_req_y_i  : b_req_y_i;
    assign alu_res = alu_eval(alu_op, alu_x, alu_y);

    always_comb begin
        a_vld_d = a_vld_q;
        a_res_d = a_res_q;
        b_vld_d = b_vld_q;
        b_res_d = b_res_q;
        if (grant_a) begin
            a_vld_d = 1'b1;
            a_res_d = alu_res;
        end else if (a_rsp_ready_i) begin
            a_vld_d = 1'b0;
        end
        if (grant_b) begin
            b_vld_d = 1'b1;
            b_res_d = alu_res;
        end else if (b_rsp_ready_i) begin
            b_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld_q <= 1'b0;
            b_vld_q <= 1'b0;
            a_res_q <= 9'd0;
            b_res_q <= 9'd0;
            rr_q    <= 1'b1;
        end else begin
            a_vld_q <= a_vld_d;
            b_vld_q <= b_vld_d;
            a_res_q <= a_res_d;
            b_res_q <= b_res_d;
            if (grant_a)      rr_q <= 1'b0;
            else if (grant_b) rr_q <= 1'b1;
        end
    end

    assign own_valid   = (lock_q == OWN_A) ? a_req_valid_i : b_req_valid_i;
    assign own_grant   = (lock_q == OWN_A) ? grant_a       : grant_b;
    assign own_lock    = (lock_q == OWN_A) ? a_req_lock_i  : b_req_lock_i;
    assign timeout_hit = (LOCK_TIMEOUT != 0) && (cnt_q == TMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= FREE;
            cnt_q  <= '0;
        end else begin
            case (lock_q)
                FREE: begin
                    cnt_q <= '0;
                    if (grant_a && a_req_lock_i)      lock_q <= OWN_A;
                    else if (grant_b && b_req_lock_i) lock_q <= OWN_B;
                end
                OWN_A, OWN_B: begin
                    // An owner accept decides the lock outright; timeout only applies otherwise.
                    if (own_grant) begin
                        cnt_q <= '0;
                        if (!own_lock) lock_q <= FREE;
                    end else if (timeout_hit) begin
                        cnt_q  <= '0;
                        lock_q <= FREE;
                    end else if (own_valid) begin
                        cnt_q <= '0;
                    end else if (LOCK_TIMEOUT != 0 && cnt_q != TMO) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    lock_q <= FREE;
                    cnt_q  <= '0;
                end
            endcase
        end
    end

    assign a_rsp_valid_o = a_vld_q;
    assign a_rsp_data_o  = a_res_q[7:0];
    assign a_rsp_carry_o = a_res_q[8];
    assign b_rsp_valid_o = b_vld_q;
    assign b_rsp_data_o  = b_res_q[7:0];
    assign b_rsp_carry_o = b_res_q[8];

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter, built with a short lock timeout.
`default_nettype none

module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req_valid = 0, a_req_lock = 0, a_rsp_ready = 1;
    logic       b_req_valid = 0, b_req_lock = 0, b_rsp_ready = 1;
    logic [3:0] a_req_op = 0, b_req_op = 0;
    logic [7:0] a_req_x = 0, a_req_y = 0, b_req_x = 0, b_req_y = 0;
    logic       a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
    logic       a_rsp_carry, b_rsp_carry;
    logic [7:0] a_rsp_data, b_rsp_data;

    int checks = 0;
    int errors = 0;
    logic [8:0] qa[$];
    logic [8:0] qb[$];

    always #5 clk = ~clk;

    alu_arbiter #(.LOCK_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid_i(a_req_valid), .a_req_ready_o(a_req_ready), .a_req_op_i(a_req_op),
        .a_req_x_i(a_req_x), .a_req_y_i(a_req_y), .a_req_lock_i(a_req_lock),
        .a_rsp_valid_o(a_rsp_valid), .a_rsp_ready_i(a_rsp_ready),
        .a_rsp_data_o(a_rsp_data), .a_rsp_carry_o(a_rsp_carry),
        .b_req_valid_i(b_req_valid), .b_req_ready_o(b_req_ready), .b_req_op_i(b_req_op),
        .b_req_x_i(b_req_x), .b_req_y_i(b_req_y), .b_req_lock_i(b_req_lock),
        .b_rsp_valid_o(b_rsp_valid), .b_rsp_ready_i(b_rsp_ready),
        .b_rsp_data_o(b_rsp_data), .b_rsp_carry_o(b_rsp_carry)
    );

    function automatic logic [8:0] model(input logic [3:0] op, input logic [7:0] x,
                                         input logic [7:0] y);
        int s;
        case (op)
            4'h0: return {1'b0, y};
            4'h1: return {1'b0, x | y};
            4'h2: return {1'b0, x & y};
            4'h3: return {1'b0, x ^ y};
            4'h4: begin s = int'(x) + int'(y); return s[8:0]; end
            4'h5: begin s = (int'(x) - int'(y)) & 255; return {(x >= y), s[7:0]}; end
            4'h6: return {x[0], 1'b0, x[7:1]};
            4'h7: begin s = (int'(y) - int'(x)) & 255; return {(y >= x), s[7:0]}; end
            4'hF: begin s = (int'(x) * 2) & 255; return {x[7], s[7:0]}; end
            default: return 9'd0;
        endcase
    endfunction

    // Scoreboard: push on accept, pop and compare on response drain.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_rsp_valid && a_rsp_ready) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL a_rsp_unexpected: got %h/%b, none expected", a_rsp_data, a_rsp_carry);
                end else begin
                    logic [8:0] e;
                    e = qa.pop_front();
                    if ({a_rsp_carry, a_rsp_data} !== e) begin
                        errors++;
                        $display("FAIL a_rsp_data: got %h/%b, expected %h/%b", a_rsp_data, a_rsp_carry, e[7:0], e[8]);
                    end
                end
            end
            if (b_rsp_valid && b_rsp_ready) begin
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL b_rsp_unexpected: got %h/%b, none expected", b_rsp_data, b_rsp_carry);
                end else begin
                    logic [8:0] e;
                    e = qb.pop_front();
                    if ({b_rsp_carry, b_rsp_data} !== e) begin
                        errors++;
                        $display("FAIL b_rsp_data: got %h/%b, expected %h/%b", b_rsp_data, b_rsp_carry, e[7:0], e[8]);
                    end
                end
            end
            if (a_req_valid && a_req_ready) qa.push_back(model(a_req_op, a_req_x, a_req_y));
            if (b_req_valid && b_req_ready) qb.push_back(model(b_req_op, b_req_x, b_req_y));
            if (a_req_ready && b_req_ready) begin
                errors++;
                $display("FAIL both_ready: a=%b b=%b, expected at most one", a_req_ready, b_req_ready);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [3:0] op, input logic [7:0] x,
                         input logic [7:0] y, input logic lk);
        a_req_valid = v; a_req_op = op; a_req_x = x; a_req_y = y; a_req_lock = lk;
    endtask

    task automatic set_b(input logic v, input logic [3:0] op, input logic [7:0] x,
                         input logic [7:0] y, input logic lk);
        b_req_valid = v; b_req_op = op; b_req_x = x; b_req_y = y; b_req_lock = lk;
    endtask

    task automatic test_reset();
        set_a(1, 4'h4, 8'h11, 8'h22, 0);
        set_b(1, 4'h1, 8'h33, 8'h44, 0);
        repeat (2) @(negedge clk);
        checks++;
        if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b%b vld=%b%b, expected 0000", a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid);
        end
        checks++;
        if ({a_rsp_carry, a_rsp_data, b_rsp_carry, b_rsp_data} !== 18'd0) begin
            errors++;
            $display("FAIL reset_data: got a=%h/%b b=%h/%b, expected 00/0", a_rsp_data, a_rsp_carry, b_rsp_data, b_rsp_carry);
        end
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_round_robin();
        set_a(1, 4'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0);
        set_b(1, 4'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0);
        for (int i = 0; i < 8; i++) begin
            logic ga, gb;
            @(negedge clk);
            ga = a_req_ready;
            gb = b_req_ready;
            checks++;
            if ({ga, gb} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got a=%b b=%b, expected %s", i, ga, gb, (i % 2 == 0) ? "A" : "B");
            end
            step();
            if (ga) set_a(1, 4'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0);
            if (gb) set_b(1, 4'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0);
        end
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
    endtask

    task automatic test_single();
        set_a(1, 4'h4, 8'hF0, 8'h20, 0);
        @(negedge clk);
        checks++;
        if (a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_ready: got %b, expected 1", a_req_ready);
        end
        step();
        checks++;
        if ({a_rsp_valid, a_rsp_carry, a_rsp_data} !== {2'b11, 8'h10}) begin
            errors++;
            $display("FAIL add_result: got v=%b %h/%b, expected v=1 10/1", a_rsp_valid, a_rsp_data, a_rsp_carry);
        end
        set_a(1, 4'h5, 8'h05, 8'h07, 0);
        step();
        checks++;
        if ({a_rsp_valid, a_rsp_carry, a_rsp_data} !== {2'b10, 8'hFE}) begin
            errors++;
            $display("FAIL sub_result: got v=%b %h/%b, expected v=1 fe/0", a_rsp_valid, a_rsp_data, a_rsp_carry);
        end
        set_a(0, 0, 0, 0, 0);
    endtask

    task automatic test_lock();
        set_a(1, 4'h1, 8'h0F, 8'h30, 1);
        @(negedge clk);
        checks++;
        if (a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL lock_first: got a_ready=%b, expected 1", a_req_ready);
        end
        step();
        set_b(1, 4'h3, 8'hAA, 8'h55, 0);
        for (int k = 0; k < 3; k++) begin
            set_a(1, 4'(k + 2), 8'(k * 17 + 3), 8'h0C, (k < 2));
            @(negedge clk);
            checks++;
            if ({a_req_ready, b_req_ready} !== 2'b10) begin
                errors++;
                $display("FAIL lock_hold[%0d]: got a=%b b=%b, expected a=1 b=0", k, a_req_ready, b_req_ready);
            end
            step();
        end
        set_a(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (b_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL lock_release: got b_ready=%b, expected 1", b_req_ready);
        end
        step();
        set_b(0, 0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        set_a(1, 4'h4, 8'h01, 8'h02, 1);
        @(negedge clk);
        checks++;
        if (a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL tmo_lock: got a_ready=%b, expected 1", a_req_ready);
        end
        step();
        set_a(0, 0, 0, 0, 0);
        set_b(1, 4'h7, 8'h10, 8'h08, 0);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (b_req_ready !== (k == 5)) begin
                errors++;
                $display("FAIL tmo_wait[%0d]: got b_ready=%b, expected %b", k, b_req_ready, (k == 5));
            end
            step();
        end
        set_b(0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        a_rsp_ready = 0;
        set_a(1, 4'h2, 8'hF3, 8'h3C, 0);
        @(negedge clk);
        checks++;
        if (a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: got a_ready=%b, expected 1", a_req_ready);
        end
        step();
        set_a(1, 4'h6, 8'h8B, 8'h00, 0);
        set_b(1, 4'h0, 8'h00, 8'h5A, 0);
        @(negedge clk);
        checks++;
        if ({a_req_ready, b_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_stall: got a=%b b=%b, expected a=0 b=1", a_req_ready, b_req_ready);
        end
        step();
        set_b(0, 0, 0, 0, 0);
        a_rsp_ready = 1;
        @(negedge clk);
        checks++;
        if ({a_req_ready, a_rsp_valid} !== 2'b11) begin
            errors++;
            $display("FAIL bp_drain: got ready=%b rsp_valid=%b, expected 1 1", a_req_ready, a_rsp_valid);
        end
        step();
        checks++;
        if ({a_rsp_valid, a_rsp_carry, a_rsp_data} !== {2'b11, 8'h45}) begin
            errors++;
            $display("FAIL bp_reload: got v=%b %h/%b, expected v=1 45/1", a_rsp_valid, a_rsp_data, a_rsp_carry);
        end
        set_a(0, 0, 0, 0, 0);
    endtask

    task automatic test_opcodes();
        for (int op = 0; op < 16; op++) begin
            logic [7:0] x;
            x = (op >= 8) ? 8'h81 : 8'($urandom);
            set_a(1, 4'(op), x, 8'h3C, 0);
            step();
            if (op >= 8) begin
                checks++;
                if ({a_rsp_carry, a_rsp_data} !== ((op == 15) ? 9'h102 : 9'h000)) begin
                    errors++;
                    $display("FAIL opcode_%0h: got %h/%b, expected %s", op, a_rsp_data, a_rsp_carry, (op == 15) ? "02/1" : "00/0");
                end
            end
        end
        set_a(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_lock();
        a_rsp_ready = 0;
        set_a(1, 4'h1, 8'h12, 8'h34, 1);
        step();
        set_a(0, 0, 0, 0, 0);
        set_b(1, 4'h4, 8'h80, 8'h80, 0);
        #2;
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        checks++;
        if ({a_rsp_valid, b_rsp_valid, a_rsp_data} !== 10'd0) begin
            errors++;
            $display("FAIL rst_mid: got vld=%b%b a_data=%h, expected 00 00", a_rsp_valid, b_rsp_valid, a_rsp_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_rsp_ready = 1;
        @(negedge clk);
        checks++;
        if (b_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_unlock: got b_ready=%b, expected 1", b_req_ready);
        end
        step();
        set_b(0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_lock();
        test_timeout();
        test_back_to_back();
        test_opcodes();
        test_reset_mid_lock();
        a_rsp_ready = 1;
        b_rsp_ready = 1;
        repeat (3) step();
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d/%0d pending, expected 0/0", qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 8-bit combinational ALU between two requesters (A and B) with per-requester valid/ready request channels and registered, back-pressurable response channels. Round-robin arbitration issues at most one ALU operation per cycle. A lock mechanism lets a requester own the ALU for a multi-operation sequence, with a timeout so an idle owner cannot starve the other requester. The block instantiates the ALU internally and sits between the sequencing masters and the datapath.

## Interface
- LOCK_TIMEOUT, 15: idle cycles with owner `*_req_valid` low before a lock is force-released; 0 disables the timeout.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- a_req_valid / b_req_valid  in  1  request present.
- a_req_ready / b_req_ready  out  1  request accepted this cycle when valid&ready.
- a_req_op / b_req_op  in  4  ALU opcode.
- a_req_x, a_req_y / b_req_x, b_req_y  in  8  operands.
- a_req_lock / b_req_lock  in  1  keep ownership after this op.
- a_rsp_valid / b_rsp_valid  out  1  result held.
- a_rsp_ready / b_rsp_ready  in  1  consumer takes result.
- a_rsp_data / b_rsp_data  out  8  result.
- a_rsp_carry / b_rsp_carry  out  1  carry/flag.

## Operation
- Opcodes: 0 out=y; 1 x|y; 2 x&y; 3 x^y (carry 0 for 0-3); 4 {carry,out}=x+y (9-bit sum); 5 out=x-y mod 256, carry=(x>=y); 6 out=x>>1, carry=x[0]; 7 out=y-x mod 256, carry=(y>=x); F out=x<<1 (mod 256), carry=x[7]; all others out=0, carry=0.
- Slot free(i) = !i_rsp_valid || i_rsp_ready.
- Eligible(i) = i_req_valid && free(i) && (no lock owner || owner==i).
- Grant: if both eligible, grant the requester not granted most recently (rr pointer); else grant the single eligible one. `i_req_ready` = grant(i); at most one ready high per cycle. Ready is combinational from valid, rsp_ready, lock and pointer state.
- On accept by i: ALU evaluates i's op/x/y; result and carry registered into i's response slot; i_rsp_valid set; rr pointer records i.
- Response slot: cleared by rsp_valid&rsp_ready with no new accept; simultaneous drain and accept loads the new result, rsp_valid stays 1.
- Lock states: FREE, OWN_A, OWN_B. FREE -> OWN_i on accept by i with i_req_lock=1. OWN_i -> FREE on accept by i with i_req_lock=0, or on timeout. OWN_i -> OWN_i on accept with lock=1 (refresh).
- Timeout counter: counts cycles in OWN_i with i_req_valid low, clears on any owner valid, saturates; reaching LOCK_TIMEOUT forces FREE on the next edge. The other requester can be granted in the cycle after release.
- Owner valid high but slot full (stalled): counter does not increment; lock held.

## Timing
- Reset values: all *_rsp_valid 0, *_rsp_data 0x00, *_rsp_carry 0, lock FREE, counter 0, rr pointer = B (A wins first tie). *_req_ready is 0 during reset.
- Latency: accept at edge N -> i_rsp_valid/data/carry valid from edge N+1.
- Throughput: one op per cycle total; one requester alone with rsp_ready held 1 sustains one op/cycle.
- Reset mid-operation: pending results discarded, lock released immediately (asynchronous).
- Requesters hold op/x/y/lock stable while valid&!ready (standard valid/ready).

## Test plan
- Single A ADD x=0xF0, y=0x20, rsp_ready=1 -> accept cycle 0, a_rsp_data=0x10, carry=1 at cycle 1; SUB_X_Y x=0x05, y=0x07 -> 0xFE, carry 0.
- A and B both valid continuously, rsp_ready=1 -> grants alternate A,B,A,B; first grant A after reset; each response is the correct requester's result.
- A accepts with lock=1 three times, B valid throughout -> B ready 0 until A's op with lock=0; then B granted next cycle.
- LOCK_TIMEOUT=4: A locks, drops valid -> B granted exactly 5 cycles after A's last accept (4 idle counts then release edge).
- a_rsp_ready=0 after one result -> a_req_ready 0, B still served; raising a_rsp_ready with A valid -> drain and new accept same cycle, a_rsp_valid stays 1.
- Opcodes 8-E and SHL x=0x81 -> out 0x00/carry 0; SHL gives 0x02, carry 1; rst_n low mid-lock -> all rsp_valid 0, lock FREE.
